// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: handshake bundle between two operand requesters, one result
// consumer and the shared-adder arbiter.
//   req0_*/req1_* : valid/ready operand channels (x, y are 5-bit unsigned)
//   rsp_*         : valid/ready result channel (id, 5-bit sum, carry out)
// Modports: master = requesters/consumer side, slave = arbiter side.
interface adder_arbiter_if;
  logic       req0_valid;
  logic [4:0] req0_x;
  logic [4:0] req0_y;
  logic       req0_ready;
  logic       req1_valid;
  logic [4:0] req1_x;
  logic [4:0] req1_y;
  logic       req1_ready;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [4:0] rsp_s;
  logic       rsp_c5;

  modport master (
    output req0_valid, req0_x, req0_y,
    input  req0_ready,
    output req1_valid, req1_x, req1_y,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_s, rsp_c5,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_x, req0_y,
    output req0_ready,
    input  req1_valid, req1_x, req1_y,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_s, rsp_c5,
    input  rsp_ready
  );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one 5-bit adder (carry-in 0). A round-robin
// arbiter grants one requester in IDLE, the operands are summed in EXEC and the
// result is offered in RESP until the consumer takes it (one op per 3 cycles).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : adder_arbiter_if.slave (request channels 0/1, response channel)
//   ovf_cnt    : count of delivered results with carry out, wraps at 2^CNT_W
//                (only when ADDER_ARB_OVF_CNT_EN is defined)
// Build option: define ADDER_ARB_OVF_CNT_EN to add the overflow counter.
module adder_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  adder_arbiter_if.slave  bus
`ifdef ADDER_ARB_OVF_CNT_EN
  ,
  output logic [CNT_W-1:0] ovf_cnt
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [4:0] x_q, x_d;
  logic [4:0] y_q, y_d;
  logic       id_q, id_d;
  logic [4:0] s_q, s_d;
  logic       c5_q, c5_d;
  logic       rsp_id_q, rsp_id_d;

  logic grant;
  logic accept;
  logic rsp_fire;

  // Round-robin: a lone requester always wins; on contention the one that did
  // not win last time gets the adder.
  always_comb begin
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end
  end

  // rst_n gates the readies so nothing looks accepted while reset is held.
  assign accept         = rst_n && (state_q == StIdle) && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;
  assign rsp_fire       = (state_q == StResp) && bus.rsp_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    x_d          = x_q;
    y_d          = y_q;
    id_d         = id_q;
    s_d          = s_q;
    c5_d         = c5_q;
    rsp_id_d     = rsp_id_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          x_d          = grant ? bus.req1_x : bus.req0_x;
          y_d          = grant ? bus.req1_y : bus.req0_y;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = StExec;
        end
      end
      StExec: begin
        {c5_d, s_d} = {1'b0, x_q} + {1'b0, y_q};
        rsp_id_d    = id_q;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_fire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      x_q          <= '0;
      y_q          <= '0;
      id_q         <= 1'b0;
      s_q          <= '0;
      c5_q         <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      x_q          <= x_d;
      y_q          <= y_d;
      id_q         <= id_d;
      s_q          <= s_d;
      c5_q         <= c5_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_s     = s_q;
  assign bus.rsp_c5    = c5_q;

`ifdef ADDER_ARB_OVF_CNT_EN
  logic [CNT_W-1:0] ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else if (rsp_fire && c5_q) begin
      ovf_q <= ovf_q + CNT_W'(1);
    end
  end

  assign ovf_cnt = ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: a vector table plus randomized
// operations checked against a reference model of the arbitration rule and the
// plain arithmetic sum, and hand-written contention / reset sequences.
module tb_adder_arbiter;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_arbiter_if bus ();
`ifdef ADDER_ARB_OVF_CNT_EN
  logic [CW-1:0] ovf_cnt;
`endif

  adder_arbiter #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ADDER_ARB_OVF_CNT_EN
    ,
    .ovf_cnt (ovf_cnt)
`endif
  );

  typedef struct {
    logic       v0;
    logic [4:0] x0;
    logic [4:0] y0;
    logic       v1;
    logic [4:0] x1;
    logic [4:0] y1;
    int         stall;
    int         id;
    int         s;
    int         c5;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int last_grant_m = 1;
  int ovf_m = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v0, input int x0, input int y0, input logic v1,
                              input int x1, input int y1, input int stall, input int id,
                              input int s, input int c5);
    vec_t v;
    v.v0 = v0; v.x0 = 5'(x0); v.y0 = 5'(y0);
    v.v1 = v1; v.x1 = 5'(x1); v.y1 = 5'(y1);
    v.stall = stall; v.id = id; v.s = s; v.c5 = c5;
    return v;
  endfunction

  function automatic int model_grant(input logic v0, input logic v1);
    if (v0 && v1) return (last_grant_m == 0) ? 1 : 0;
    return v1 ? 1 : 0;
  endfunction

  task automatic model_reset();
    last_grant_m = 1;
    ovf_m = 0;
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge after the handshake.
  task automatic run_op(input vec_t v, input string tag);
    bus.req0_valid = v.v0; bus.req0_x = v.x0; bus.req0_y = v.y0;
    bus.req1_valid = v.v1; bus.req1_x = v.x1; bus.req1_y = v.y1;
    bus.rsp_ready = 1'b1;
    #1;
    check({tag, " ready0"}, int'(bus.req0_ready), (v.id == 0) ? 1 : 0);
    check({tag, " ready1"}, int'(bus.req1_ready), (v.id == 1) ? 1 : 0);
    @(posedge clk);
    last_grant_m = v.id;
    @(negedge clk);
    // Scramble operands after acceptance; late requests must be ignored.
    bus.req0_valid = 1'($urandom_range(0, 1)); bus.req0_x = 5'($urandom); bus.req0_y = 5'($urandom);
    bus.req1_valid = 1'($urandom_range(0, 1)); bus.req1_x = 5'($urandom); bus.req1_y = 5'($urandom);
    bus.rsp_ready = (v.stall == 0);
    #1;
    check({tag, " exec rsp_valid"}, int'(bus.rsp_valid), 0);
    check({tag, " exec readies"}, int'(bus.req0_ready | bus.req1_ready), 0);
    for (int i = 0; i <= v.stall; i++) begin
      @(negedge clk);
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      check({tag, " resp rsp_valid"}, int'(bus.rsp_valid), 1);
      check({tag, " resp rsp_id"}, int'(bus.rsp_id), v.id);
      check({tag, " resp rsp_s"}, int'(bus.rsp_s), v.s);
      check({tag, " resp rsp_c5"}, int'(bus.rsp_c5), v.c5);
      check({tag, " resp readies"}, int'(bus.req0_ready | bus.req1_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    if (v.c5 != 0) ovf_m = (ovf_m + 1) % (1 << CW);
    @(negedge clk);
    check({tag, " post rsp_valid"}, int'(bus.rsp_valid), 0);
`ifdef ADDER_ARB_OVF_CNT_EN
    check({tag, " ovf_cnt"}, int'(ovf_cnt), ovf_m);
`endif
  endtask

  vec_t tbl[11];

  initial begin
    vec_t rv;
    int   exp_id;
    int   resp_cnt;
    int   sum;

    tbl[0]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 2, 0);
    tbl[1]  = mk(1, 17, 19, 0, 0, 0, 0, 0, 4, 1);
    tbl[2]  = mk(0, 0, 0, 1, 31, 31, 5, 1, 30, 1);
    tbl[3]  = mk(1, 1, 31, 1, 3, 4, 0, 0, 0, 1);
    tbl[4]  = mk(1, 10, 15, 1, 2, 5, 0, 1, 7, 0);
    tbl[5]  = mk(1, 10, 15, 1, 2, 5, 0, 0, 25, 0);
    tbl[6]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    tbl[7]  = mk(1, 16, 16, 0, 0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(1, 31, 1, 1, 31, 31, 0, 1, 30, 1);
    tbl[9]  = mk(1, 31, 31, 0, 0, 0, 0, 0, 30, 1);
    tbl[10] = mk(1, 1, 1, 0, 0, 0, 2, 0, 2, 0);

    // Reset state with both requesters asserting.
    bus.req0_valid = 1'b1; bus.req0_x = 5'd10; bus.req0_y = 5'd15;
    bus.req1_valid = 1'b1; bus.req1_x = 5'd2;  bus.req1_y = 5'd5;
    bus.rsp_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset readies", int'(bus.req0_ready | bus.req1_ready), 0);
    check("reset rsp_valid", int'(bus.rsp_valid), 0);
    check("reset rsp_id", int'(bus.rsp_id), 0);
    check("reset rsp_s", int'(bus.rsp_s), 0);
    check("reset rsp_c5", int'(bus.rsp_c5), 0);
`ifdef ADDER_ARB_OVF_CNT_EN
    check("reset ovf_cnt", int'(ovf_cnt), 0);
`endif

    // Contention straight out of reset: ids alternate 0,1,0,1.
    @(negedge clk);
    rst_n = 1'b1;
    exp_id = 0;
    resp_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c == 0) check("first grant ready0", int'(bus.req0_ready), 1);
      check("contention one ready", int'(bus.req0_ready & bus.req1_ready), 0);
      if (bus.rsp_valid) begin
        check("contention rsp_id", int'(bus.rsp_id), exp_id);
        check("contention rsp_s", int'(bus.rsp_s), (exp_id == 0) ? 25 : 7);
        check("contention rsp_c5", int'(bus.rsp_c5), 0);
        exp_id = 1 - exp_id;
        resp_cnt++;
      end
    end
    check("contention responses", resp_cnt, 4);
    last_grant_m = 1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i], $sformatf("tbl%0d", i));
    end

    // Reset while in EXEC discards the in-flight op.
    bus.req0_valid = 1'b1; bus.req0_x = 5'd4; bus.req0_y = 5'd4;
    bus.req1_valid = 1'b1; bus.req1_x = 5'd6; bus.req1_y = 5'd6;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst rsp_valid", int'(bus.rsp_valid), 0);
    check("midrst readies", int'(bus.req0_ready | bus.req1_ready), 0);
    model_reset();
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("midrst no response", int'(bus.rsp_valid), 0);
    end
    @(negedge clk);
    run_op(mk(1, 4, 4, 1, 6, 6, 0, 0, 8, 0), "midrst regrant");

    // Overflow counter sequence: 31+31 five times, then 1+1.
    for (int i = 0; i < 5; i++) run_op(mk(1, 31, 31, 0, 0, 0, 0, 0, 30, 1), "ovf carry");
    for (int i = 0; i < 2; i++) run_op(mk(1, 1, 1, 0, 0, 0, 0, 0, 2, 0), "ovf nocarry");

    // Randomized operations against the model.
    for (int i = 0; i < 60; i++) begin
      rv.v0 = 1'($urandom_range(0, 1));
      rv.v1 = 1'($urandom_range(0, 1));
      if (!rv.v0 && !rv.v1) rv.v0 = 1'b1;
      rv.x0 = 5'($urandom); rv.y0 = 5'($urandom);
      rv.x1 = 5'($urandom); rv.y1 = 5'($urandom);
      rv.stall = int'($urandom_range(0, 3));
      rv.id = model_grant(rv.v0, rv.v1);
      sum = (rv.id == 0) ? (int'(rv.x0) + int'(rv.y0)) : (int'(rv.x1) + int'(rv.y1));
      rv.s = sum % 32;
      rv.c5 = sum / 32;
      run_op(rv, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: CNT_W, 8, width of overflow counter (used only under ADDER_ARB_OVF_CNT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has operands.
REQ-005 req0_x, req0_y  input  5 each  requester 0 operands, unsigned.
REQ-006 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 req1_valid, req1_x, req1_y, req1_ready  same as REQ-004..006, requester 1.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer takes result.
REQ-010 rsp_id  output  1  requester index owning result.
REQ-011 rsp_s  output  5  sum bits [4:0].
REQ-012 rsp_c5  output  1  carry out of bit 4.
REQ-013 ovf_cnt  output  CNT_W  count of delivered results with rsp_c5=1 (present only under ADDER_ARB_OVF_CNT_EN).

Function
REQ-014 Block SHALL share one 5-bit adder (carry-in 0) between two requesters; FSM states IDLE, EXEC, RESP.
REQ-015 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally that cycle, capture its x/y and index, go EXEC; else stay IDLE.
REQ-016 reqN_ready SHALL be 0 outside IDLE and 0 for the non-granted requester; at most one ready high per cycle.
REQ-017 Arbitration round-robin: pointer last_grant; only one valid -> grant it; both valid -> grant requester != last_grant; last_grant updates on every grant.
REQ-018 EXEC (exactly one cycle): register {rsp_c5, rsp_s} = x + y (6-bit result), rsp_id = captured index; go RESP.
REQ-019 RESP: rsp_valid=1; rsp_id/rsp_s/rsp_c5 SHALL remain stable until rsp_valid && rsp_ready, then go IDLE with rsp_valid=0 next cycle.
REQ-020 Latency: accept at edge T -> rsp_valid high from cycle T+2; with rsp_ready held 1, next accept earliest at cycle T+3 (throughput 1 per 3 cycles).
REQ-021 Requests not granted SHALL be ignored (no internal queuing); requesters hold valid and operands until ready.
REQ-022 rsp_ready while not RESP SHALL have no effect.
REQ-023 Operands changing after acceptance SHALL not affect the in-flight result.

Reset
REQ-024 rst_n low SHALL immediately force: state=IDLE, rsp_valid=0, rsp_id=0, rsp_s=0, rsp_c5=0, last_grant=1 (requester 0 wins first contest), ovf_cnt=0; req0_ready=req1_ready=0 while rst_n low.
REQ-025 Reset in EXEC or RESP SHALL discard the in-flight result; no response emitted after release.
REQ-026 First grant SHALL be possible in the first clock edge after rst_n deasserts.

Configuration
REQ-027 Macro ADDER_ARB_OVF_CNT_EN defined: ovf_cnt port exists; increments by 1 on each response handshake with rsp_c5=1; wraps from 2^CNT_W-1 to 0.
REQ-028 ADDER_ARB_OVF_CNT_EN undefined: no ovf_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-029 Single op: req0 x=1,y=1, rsp_ready=1 -> rsp_valid at T+2, rsp_id=0, rsp_s=2, rsp_c5=0.
REQ-030 Carry/edge sums: x=17,y=19 -> rsp_s=4, rsp_c5=1; x=31,y=31 -> rsp_s=30, rsp_c5=1; x=1,y=31 -> rsp_s=0, rsp_c5=1.
REQ-031 Contention: after reset both valid continuously (req0 10+15, req1 2+5) -> responses alternate id 0 (s=25,c5=0), id 1 (s=7,c5=0), id 0, ...; never two readies same cycle.
REQ-032 Backpressure: rsp_ready=0 for 5 cycles in RESP -> outputs stable, rsp_valid held, both readies 0; rsp_ready=1 -> handshake, IDLE next cycle.
REQ-033 Reset mid-op: rst_n low during EXEC -> rsp_valid 0 immediately, no response after release, next contest granted to req0.
REQ-034 With ADDER_ARB_OVF_CNT_EN, CNT_W=2: five responses of 31+31 -> ovf_cnt 1,2,3,0,1; 1+1 responses leave ovf_cnt unchanged.
